// File: rtl/bias_store_pkg.sv
// Shared constants and write-side FSM encoding for the double-buffered bias store.
package bias_store_pkg;

    localparam int unsigned DefaultBiasW = 32;
    localparam int unsigned DefaultWrW   = 128;
    localparam int unsigned DefaultLanes = 8;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StFull
    } wr_state_e;

endpackage

// File: rtl/bias_bank.sv
// One bias bank: narrow write port, wide synchronous read port returning a whole group.
module bias_bank #(
    parameter int unsigned WR_W       = 128,
    parameter int unsigned BPG        = 2,
    parameter int unsigned MAX_GROUPS = 128,
    parameter int unsigned GRP_W      = 8,
    parameter int unsigned AW         = 8
) (
    input  logic                clk_i,
    input  logic                we_i,
    input  logic [AW-1:0]       waddr_i,
    input  logic [WR_W-1:0]     wdata_i,
    input  logic                re_i,
    input  logic [GRP_W-1:0]    rgroup_i,
    output logic [BPG*WR_W-1:0] rdata_o
);

    localparam int unsigned Depth = MAX_GROUPS * BPG;

    logic [WR_W-1:0]     mem_q [Depth];
    logic [BPG*WR_W-1:0] rdata_q;
    logic [AW-1:0]       rbase;

    assign rbase   = AW'(rgroup_i) * AW'(BPG);
    assign rdata_o = rdata_q;

    // Read data is left unreset; the top gates it with its own valid flag.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            for (int k = 0; k < BPG; k++) begin
                rdata_q[k*WR_W +: WR_W] <= mem_q[rbase + AW'(k)];
            end
        end
    end

endmodule

// File: rtl/bias_store_db.sv
// Double-buffered bias store: beats load the shadow bank, swap promotes it, reads hit the active bank.
module bias_store_db
    import bias_store_pkg::*;
#(
    parameter int unsigned  BIAS_W     = DefaultBiasW,
    parameter int unsigned  WR_W       = DefaultWrW,
    parameter int unsigned  LANES      = DefaultLanes,
    parameter int unsigned  MAX_GROUPS = 128,
    localparam int unsigned GRP_W      = $clog2(MAX_GROUPS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic [GRP_W-1:0]  load_groups,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [WR_W-1:0]   wr_data,
    output logic              load_done,
    input  logic              swap,
    input  logic              rd_en,
    input  logic [GRP_W-1:0]  rd_group,
    output logic [BIAS_W-1:0] bias_out [LANES],
    output logic              rd_valid,
    output logic              rd_err,
    output logic [GRP_W-1:0]  active_groups
);

    localparam int unsigned Bpg   = LANES * BIAS_W / WR_W;
    localparam int unsigned Depth = MAX_GROUPS * Bpg;
    localparam int unsigned Aw    = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW  = $clog2(Depth + 1);

    wr_state_e        state_q, state_d;
    logic [CntW-1:0]  beat_q, beat_d;
    logic [GRP_W-1:0] groups_q, groups_d;
    logic             active_q, active_d;
    logic [GRP_W-1:0] act_groups_q, act_groups_d;
    logic             rd_valid_q, rd_err_q, rd_bank_q;

    logic [GRP_W-1:0]      load_clamped;
    logic [CntW-1:0]       last_beat;
    logic                  beat_acc;
    logic                  rd_hit;
    logic [Aw-1:0]         waddr;
    logic [LANES*BIAS_W-1:0] rdata0, rdata1, rdata_sel;

    assign load_clamped = (load_groups > GRP_W'(MAX_GROUPS)) ? GRP_W'(MAX_GROUPS) : load_groups;
    assign last_beat    = CntW'(groups_q) * CntW'(Bpg) - CntW'(1);
    assign wr_ready     = (state_q == StLoad);
    assign load_done    = (state_q == StFull);
    assign beat_acc     = wr_valid & wr_ready;
    assign waddr        = Aw'(beat_q);
    assign rd_hit       = rd_en & (rd_group < act_groups_q);

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        groups_d     = groups_q;
        active_d     = active_q;
        act_groups_d = act_groups_q;
        unique case (state_q)
            StIdle, StLoad: begin
                if (load_start) begin
                    groups_d = load_clamped;
                    beat_d   = '0;
                    state_d  = (load_clamped == '0) ? StFull : StLoad;
                end else if (beat_acc) begin
                    beat_d = beat_q + CntW'(1);
                    if (beat_q == last_beat) begin
                        state_d = StFull;
                    end
                end
            end
            StFull: begin
                // A swap commits the full shadow bank before any new load is considered.
                if (swap) begin
                    active_d     = ~active_q;
                    act_groups_d = groups_q;
                    state_d      = StIdle;
                end else if (load_start) begin
                    groups_d = load_clamped;
                    beat_d   = '0;
                    state_d  = (load_clamped == '0) ? StFull : StLoad;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            beat_q       <= '0;
            groups_q     <= '0;
            active_q     <= 1'b0;
            act_groups_q <= '0;
            rd_valid_q   <= 1'b0;
            rd_err_q     <= 1'b0;
            rd_bank_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            groups_q     <= groups_d;
            active_q     <= active_d;
            act_groups_q <= act_groups_d;
            rd_valid_q   <= rd_en;
            rd_err_q     <= rd_en & ~rd_hit;
            // Captures the pre-swap bank so a read alongside a swap sees the old data.
            if (rd_en) begin
                rd_bank_q <= active_q;
            end
        end
    end

    bias_bank #(
        .WR_W      (WR_W),
        .BPG       (Bpg),
        .MAX_GROUPS(MAX_GROUPS),
        .GRP_W     (GRP_W),
        .AW        (Aw)
    ) u_bank0 (
        .clk_i   (clk),
        .we_i    (beat_acc & active_q),
        .waddr_i (waddr),
        .wdata_i (wr_data),
        .re_i    (rd_hit & ~active_q),
        .rgroup_i(rd_group),
        .rdata_o (rdata0)
    );

    bias_bank #(
        .WR_W      (WR_W),
        .BPG       (Bpg),
        .MAX_GROUPS(MAX_GROUPS),
        .GRP_W     (GRP_W),
        .AW        (Aw)
    ) u_bank1 (
        .clk_i   (clk),
        .we_i    (beat_acc & ~active_q),
        .waddr_i (waddr),
        .wdata_i (wr_data),
        .re_i    (rd_hit & active_q),
        .rgroup_i(rd_group),
        .rdata_o (rdata1)
    );

    assign rdata_sel     = rd_bank_q ? rdata1 : rdata0;
    assign rd_valid      = rd_valid_q;
    assign rd_err        = rd_err_q;
    assign active_groups = act_groups_q;

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            bias_out[l] = (rd_valid_q & ~rd_err_q) ? rdata_sel[l*BIAS_W +: BIAS_W] : '0;
        end
    end

endmodule

// File: tb/tb_bias_store_db.sv
// Bench for bias_store_db: loads and reads checked against a group-level reference of both banks.
module tb_bias_store_db;

    localparam int BIAS_W     = 32;
    localparam int WR_W       = 128;
    localparam int LANES      = 8;
    localparam int MAX_GROUPS = 128;
    localparam int GRP_W      = $clog2(MAX_GROUPS + 1);
    localparam int LPB        = WR_W / BIAS_W;
    localparam int BPG        = LANES * BIAS_W / WR_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              load_start = 1'b0;
    logic [GRP_W-1:0]  load_groups = '0;
    logic              wr_valid = 1'b0;
    logic              wr_ready;
    logic [WR_W-1:0]   wr_data = '0;
    logic              load_done;
    logic              swap = 1'b0;
    logic              rd_en = 1'b0;
    logic [GRP_W-1:0]  rd_group = '0;
    logic [BIAS_W-1:0] bias_out [LANES];
    logic              rd_valid;
    logic              rd_err;
    logic [GRP_W-1:0]  active_groups;

    always #5 clk = ~clk;

    bias_store_db #(
        .BIAS_W    (BIAS_W),
        .WR_W      (WR_W),
        .LANES     (LANES),
        .MAX_GROUPS(MAX_GROUPS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_start   (load_start),
        .load_groups  (load_groups),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_data      (wr_data),
        .load_done    (load_done),
        .swap         (swap),
        .rd_en        (rd_en),
        .rd_group     (rd_group),
        .bias_out     (bias_out),
        .rd_valid     (rd_valid),
        .rd_err       (rd_err),
        .active_groups(active_groups)
    );

    // Reference: what each group of the visible and the pending buffer should hold.
    logic [BIAS_W-1:0] ref_act [MAX_GROUPS][LANES];
    logic [BIAS_W-1:0] ref_shd [MAX_GROUPS][LANES];
    int ref_groups  = 0;
    int ref_pending = 0;
    bit ref_full    = 1'b0;
    int checks = 0;
    int errors = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input int n);
        load_start  = 1'b1;
        load_groups = GRP_W'(n);
        step();
        load_start  = 1'b0;
        ref_pending = (n > MAX_GROUPS) ? MAX_GROUPS : n;
        ref_full    = (ref_pending == 0);
    endtask

    // Flat bias index within a load is group*LANES+lane; mode 0 uses base+index, else random.
    task automatic prep_beat(input int b, input int mode, input int base);
        int g;
        int l;
        logic [BIAS_W-1:0] v;
        g = b / BPG;
        for (int i = 0; i < LPB; i++) begin
            l = (b % BPG) * LPB + i;
            v = (mode != 0) ? BIAS_W'($urandom) : BIAS_W'(base + g * LANES + l);
            ref_shd[g][l] = v;
            wr_data[i*BIAS_W +: BIAS_W] = v;
        end
        wr_valid = 1'b1;
        if (b == ref_pending * BPG - 1) ref_full = 1'b1;
    endtask

    task automatic load_beats(input int first, input int last, input int mode, input int base);
        for (int b = first; b <= last; b++) begin
            wr_valid = 1'b0;
            repeat ($urandom_range(0, 1)) step();
            prep_beat(b, mode, base);
            step();
            wr_valid = 1'b0;
        end
    endtask

    task automatic do_swap();
        swap = 1'b1;
        step();
        swap = 1'b0;
        if (ref_full) begin
            ref_act    = ref_shd;
            ref_groups = ref_pending;
            ref_full   = 1'b0;
        end
    endtask

    task automatic read_burst(input int grps[$], input string tag);
        logic [BIAS_W-1:0] exp_v [LANES];
        bit exp_err;
        int bad;
        foreach (grps[i]) begin
            rd_en    = 1'b1;
            rd_group = GRP_W'(grps[i]);
            exp_err  = (grps[i] >= ref_groups);
            for (int l = 0; l < LANES; l++) begin
                exp_v[l] = '0;
                if (!exp_err) exp_v[l] = ref_act[grps[i]][l];
            end
            step();
            checks++;
            if (rd_valid !== 1'b1 || rd_err !== exp_err) begin
                errors++;
                $display("FAIL %s valid/err grp %0d got %b/%b want 1/%b",
                         tag, grps[i], rd_valid, rd_err, exp_err);
            end
            bad = -1;
            for (int l = 0; l < LANES; l++) begin
                if (bias_out[l] !== exp_v[l] && bad < 0) bad = l;
            end
            checks++;
            if (bad >= 0) begin
                errors++;
                $display("FAIL %s data grp %0d lane %0d got %0h want %0h",
                         tag, grps[i], bad, bias_out[bad], exp_v[bad]);
            end
        end
        rd_en = 1'b0;
        step();
        checks++;
        if (rd_valid !== 1'b0 || rd_err !== 1'b0) begin
            errors++;
            $display("FAIL %s idle valid/err got %b/%b want 0/0", tag, rd_valid, rd_err);
        end
    endtask

    task automatic test_reset();
        int nz;
        #1;
        nz = 0;
        for (int l = 0; l < LANES; l++) if (bias_out[l] !== '0) nz++;
        checks++;
        if ({rd_valid, rd_err, wr_ready, load_done} !== 4'b0 || active_groups !== '0 || nz != 0)
        begin
            errors++;
            $display("FAIL reset_state got v%b e%b r%b d%b ag%0d nz%0d want all zero",
                     rd_valid, rd_err, wr_ready, load_done, active_groups, nz);
        end
        step();
        rst_n = 1'b1;
        step();
        read_burst({0, 5}, "read_after_reset");
    endtask

    task automatic test_basic_load();
        start_load(4);
        checks++;
        if (wr_ready !== 1'b1 || load_done !== 1'b0) begin
            errors++;
            $display("FAIL load_enter ready/done got %b/%b want 1/0", wr_ready, load_done);
        end
        for (int b = 0; b < 4 * BPG; b++) begin
            load_beats(b, b, 0, 1);
            checks++;
            if (load_done !== (b == 4 * BPG - 1)) begin
                errors++;
                $display("FAIL load_done beat %0d got %b want %b", b, load_done, b == 4 * BPG - 1);
            end
        end
        checks++;
        if (wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_ready got %b want 0", wr_ready);
        end
        do_swap();
        checks++;
        if (active_groups !== GRP_W'(4) || load_done !== 1'b0) begin
            errors++;
            $display("FAIL swap_commit ag/done got %0d/%b want 4/0", active_groups, load_done);
        end
        for (int g = 0; g < 4; g++) read_burst({g}, "single_read");
    endtask

    task automatic test_back_to_back();
        read_burst({3, 0, 2, 1}, "b2b");
    endtask

    task automatic test_out_of_range();
        read_burst({4, 127, 128, 255, 3}, "range");
    endtask

    task automatic test_double_buffer();
        logic [BIAS_W-1:0] exp_v [LANES];
        bit exp_err;
        int g;
        int bad;
        do_swap();
        checks++;
        if (active_groups !== GRP_W'(4)) begin
            errors++;
            $display("FAIL swap_in_idle ag got %0d want 4", active_groups);
        end
        start_load(4);
        // Each beat goes to the pending buffer while a read of the visible one runs alongside.
        for (int b = 0; b < 4 * BPG; b++) begin
            prep_beat(b, 0, 100);
            g        = int'($urandom_range(0, 3));
            rd_en    = 1'b1;
            rd_group = GRP_W'(g);
            step();
            wr_valid = 1'b0;
            rd_en    = 1'b0;
            bad = -1;
            for (int l = 0; l < LANES; l++) if (bias_out[l] !== ref_act[g][l] && bad < 0) bad = l;
            checks++;
            if (rd_valid !== 1'b1 || rd_err !== 1'b0 || bad >= 0) begin
                errors++;
                $display("FAIL rw_overlap grp %0d v%b e%b lane %0d", g, rd_valid, rd_err, bad);
            end
        end
        checks++;
        if (load_done !== 1'b1) begin
            errors++;
            $display("FAIL overlap_done got %b want 1", load_done);
        end
        rd_en    = 1'b1;
        rd_group = GRP_W'(1);
        exp_err  = (1 >= ref_groups);
        for (int l = 0; l < LANES; l++) exp_v[l] = ref_act[1][l];
        do_swap();
        rd_en = 1'b0;
        bad = -1;
        for (int l = 0; l < LANES; l++) if (bias_out[l] !== exp_v[l] && bad < 0) bad = l;
        checks++;
        if (rd_valid !== 1'b1 || rd_err !== exp_err || bad >= 0) begin
            errors++;
            $display("FAIL read_with_swap v%b e%b lane %0d got %0h want %0h",
                     rd_valid, rd_err, bad, bias_out[0], exp_v[0]);
        end
        read_burst({1}, "after_swap");
    endtask

    task automatic test_restart();
        start_load(4);
        load_beats(0, 2, 0, 200);
        start_load(2);
        for (int b = 0; b < 2 * BPG; b++) begin
            load_beats(b, b, 0, 300);
            checks++;
            if (load_done !== (b == 2 * BPG - 1)) begin
                errors++;
                $display("FAIL restart_done beat %0d got %b want %b", b, load_done, b == 2 * BPG - 1);
            end
        end
        checks++;
        if (wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL restart_ready got %b want 0", wr_ready);
        end
        do_swap();
        checks++;
        if (active_groups !== GRP_W'(2)) begin
            errors++;
            $display("FAIL restart_ag got %0d want 2", active_groups);
        end
        read_burst({0, 1, 2}, "restart_read");
    endtask

    task automatic test_zero_groups();
        start_load(0);
        checks++;
        if (load_done !== 1'b1 || wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL zero_load done/ready got %b/%b want 1/0", load_done, wr_ready);
        end
        do_swap();
        checks++;
        if (active_groups !== '0) begin
            errors++;
            $display("FAIL zero_ag got %0d want 0", active_groups);
        end
        read_burst({0}, "zero_read");
    endtask

    task automatic test_clamp();
        start_load(255);
        load_beats(0, MAX_GROUPS * BPG - 1, 1, 0);
        checks++;
        if (load_done !== 1'b1) begin
            errors++;
            $display("FAIL clamp_done got %b want 1", load_done);
        end
        do_swap();
        checks++;
        if (active_groups !== GRP_W'(MAX_GROUPS)) begin
            errors++;
            $display("FAIL clamp_ag got %0d want %0d", active_groups, MAX_GROUPS);
        end
        read_burst({127, 0, 128, 64, 200}, "clamp_read");
    endtask

    task automatic test_random();
        int n;
        int q[$];
        for (int r = 0; r < 4; r++) begin
            n = int'($urandom_range(1, 6));
            start_load(n);
            load_beats(0, n * BPG - 1, 1, 0);
            do_swap();
            q = {};
            for (int i = 0; i < 6; i++) q.push_back(int'($urandom_range(0, n + 1)));
            read_burst(q, "random");
        end
    endtask

    task automatic test_reset_midload();
        int nz;
        start_load(3);
        load_beats(0, 1, 0, 400);
        rd_en    = 1'b1;
        rd_group = '0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        nz = 0;
        for (int l = 0; l < LANES; l++) if (bias_out[l] !== '0) nz++;
        checks++;
        if ({rd_valid, rd_err, wr_ready, load_done} !== 4'b0 || active_groups !== '0 || nz != 0)
        begin
            errors++;
            $display("FAIL midload_reset got v%b e%b r%b d%b ag%0d nz%0d want all zero",
                     rd_valid, rd_err, wr_ready, load_done, active_groups, nz);
        end
        rd_en = 1'b0;
        step();
        rst_n       = 1'b1;
        ref_groups  = 0;
        ref_pending = 0;
        ref_full    = 1'b0;
        step();
        do_swap();
        checks++;
        if (active_groups !== '0 || load_done !== 1'b0) begin
            errors++;
            $display("FAIL swap_after_reset ag/done got %0d/%b want 0/0", active_groups, load_done);
        end
        read_burst({0}, "post_reset_read");
        start_load(1);
        load_beats(0, BPG - 1, 0, 500);
        do_swap();
        checks++;
        if (active_groups !== GRP_W'(1)) begin
            errors++;
            $display("FAIL reload_ag got %0d want 1", active_groups);
        end
        read_burst({0, 1}, "reload_read");
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_back_to_back();
        test_out_of_range();
        test_double_buffer();
        test_restart();
        test_zero_groups();
        test_clamp();
        test_random();
        test_reset_midload();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bias_store_db.md
BIAS_STORE_DB -- requirements
Module: bias_store_db

Interface
REQ-001 Parameter BIAS_W, default 32, width of one signed bias in bits.
REQ-002 Parameter WR_W, default 128, write beat width; SHALL be a multiple of BIAS_W.
REQ-003 Parameter LANES, default 8, biases per output group; LANES*BIAS_W SHALL be a multiple of WR_W.
REQ-004 Parameter MAX_GROUPS, default 128, group capacity per bank; GRP_W = $clog2(MAX_GROUPS+1).
REQ-005 Port clk  in  1  sole clock, rising edge.
REQ-006 Port rst_n  in  1  asynchronous, active-low reset.
REQ-007 Port load_start  in  1  single-cycle pulse that begins loading the shadow bank.
REQ-008 Port load_groups  in  GRP_W  number of groups to load, sampled with load_start.
REQ-009 Port wr_valid  in  1  write beat valid.
REQ-010 Port wr_ready  out  1  shadow bank accepts a beat.
REQ-011 Port wr_data  in  WR_W  WR_W/BIAS_W biases, lowest lane in bits [BIAS_W-1:0].
REQ-012 Port load_done  out  1  level, shadow bank full and ready to swap.
REQ-013 Port swap  in  1  pulse that makes the shadow bank active.
REQ-014 Port rd_en  in  1  read request.
REQ-015 Port rd_group  in  GRP_W  group index to read.
REQ-016 Port bias_out  out  LANES x BIAS_W  unpacked array of biases for the group.
REQ-017 Port rd_valid  out  1  bias_out valid.
REQ-018 Port rd_err  out  1  the read was out of range, qualified by rd_valid.
REQ-019 Port active_groups  out  GRP_W  group count of the active bank.

Function
REQ-020 BPG = LANES*BIAS_W/WR_W beats per group; beat k of group g SHALL fill lanes [(k*WR_W/BIAS_W) +: WR_W/BIAS_W].
REQ-021 The write-side FSM SHALL have states IDLE, LOAD and FULL, and SHALL hold in IDLE after reset.
REQ-022 In IDLE or FULL, load_start SHALL latch load_groups, clear the beat counter and go to LOAD; load_groups=0 SHALL go straight to FULL.
REQ-023 In LOAD, load_start SHALL restart the load and discard the beats already written.
REQ-024 wr_ready SHALL be 1 only in LOAD; a beat is written when wr_valid and wr_ready are both 1.
REQ-025 The beat counter SHALL advance on each accepted beat; after beat load_groups*BPG-1 the FSM SHALL go to FULL on the next edge.
REQ-026 load_done SHALL be 1 exactly while in FULL.
REQ-027 swap in FULL SHALL toggle the active bank, set active_groups to the latched count and return to IDLE; swap in any other state SHALL be ignored.
REQ-028 load_groups > MAX_GROUPS SHALL be clamped to MAX_GROUPS.
REQ-029 Read latency SHALL be one cycle: rd_en at edge t gives rd_valid=1 with data after edge t+1; back-to-back rd_en SHALL give one result per cycle.
REQ-030 rd_group >= active_groups SHALL return bias_out all zero with rd_err=1.
REQ-031 A read issued in the same cycle as an accepted swap SHALL return data from the pre-swap active bank.
REQ-032 Writes SHALL only touch the shadow bank; reads SHALL only touch the active bank; a write and a read in the same cycle SHALL both complete.
REQ-033 rd_err SHALL be 0 whenever rd_valid=0.

Reset
REQ-034 On rst_n=0 the block SHALL reset immediately: FSM=IDLE, active bank=0, active_groups=0, wr_ready=0, load_done=0, rd_valid=0, rd_err=0, bias_out all zero.
REQ-035 Reset asserted mid-load or mid-read SHALL abandon the operation; RAM contents are don't-care, and every read after reset SHALL report rd_err until a swap completes.

Structure
REQ-036 Package bias_store_pkg SHALL hold the FSM state enum and the default BIAS_W, WR_W and LANES constants.
REQ-037 A sub-module bias_bank (simple dual-port RAM of MAX_GROUPS*BPG x WR_W, with a synchronous read) SHALL be instantiated twice; bank select and the output registers SHALL live in the top module.

Verification
REQ-038 Load 4 groups with bias[n]=n+1 and swap, then read groups 0..3 -> group g returns g*8+1..g*8+8 with rd_valid one cycle after rd_en and rd_err=0.
REQ-039 Out-of-order reads 3,0,2,1 issued back-to-back -> four consecutive rd_valid cycles carrying the correct data.
REQ-040 While reading bank A, load bank B with bias[n]=100+n and swap in the same cycle as a read of group 1 -> that read returns 9..16, and the next read of group 1 returns 108..115.
REQ-041 Read group 4 with active_groups=4, and read any group right after reset -> bias_out=0 and rd_err=1.
REQ-042 After 3 beats, issue load_start again with load_groups=2 -> load_done is 1 only after 4 further beats, and wr_ready=0 in FULL.
REQ-043 Drop rst_n during LOAD with reads outstanding -> all outputs read zero immediately, and swap is ignored until a new load completes.
